pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and synchronous-flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves four hazards: load-use, taken branch/jump, multi-cycle EX operations (MUL/DIV) and data-memory wait states.
- Contains a small FSM plus a countdown counter that sequences the multi-cycle unit.

---
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Central stall/flush sequencer for the 5-stage pipeline. Drives
//             the enable and synchronous-flush controls of the PC, IF/ID,
//             ID/EX, EX/MEM and MEM/WB registers. It resolves load-use,
//             taken branch/jump, multi-cycle EX (MUL/DIV) and data-memory
//             wait hazards. A two-state FSM and a countdown counter sequence
//             the multi-cycle unit.
//  Ports    : clk, reset (async, active high)
//             ID  : d_rs1, d_rs2, d_uses_rs1, d_uses_rs2
//             EX  : e_rd, e_is_load, e_pc_src, e_mc_start
//             MEM : m_mem_req, m_mem_ready
//             out : f_enable, fd_enable/flush, de_enable/flush,
//                   em_enable/flush, mw_flush, e_mc_busy, e_mc_done,
//                   perf_stall_cycles
//  Options  : PIPECTRL_PERF_EN - builds a saturating 32-bit counter of
//             cycles with f_enable==0; otherwise perf_stall_cycles is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int MC_CYCLES = 32,
   parameter int CNT_W     = $clog2(MC_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  d_rs1,
   input  logic [4:0]  d_rs2,
   input  logic        d_uses_rs1,
   input  logic        d_uses_rs2,
   input  logic [4:0]  e_rd,
   input  logic        e_is_load,
   input  logic        e_pc_src,
   input  logic        e_mc_start,
   input  logic        m_mem_req,
   input  logic        m_mem_ready,
   output logic        f_enable,
   output logic        fd_enable,
   output logic        fd_flush,
   output logic        de_enable,
   output logic        de_flush,
   output logic        em_enable,
   output logic        em_flush,
   output logic        mw_flush,
   output logic        e_mc_busy,
   output logic        e_mc_done,
   output logic [31:0] perf_stall_cycles
);

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MC_BUSY = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic mem_stall;
   logic load_use;
   logic cnt_zero;
   logic mc_hold;

   assign mem_stall = m_mem_req & ~m_mem_ready;
   assign load_use  = e_is_load & (e_rd != 5'd0) &
                      ((d_uses_rs1 & (d_rs1 == e_rd)) |
                       (d_uses_rs2 & (d_rs2 == e_rd)));
   assign cnt_zero  = (cnt == '0);
   // On the final MC_BUSY cycle (cnt==0) the hold is released so EX advances.
   assign mc_hold   = ((state == RUN) & e_mc_start) |
                      ((state == MC_BUSY) & ~cnt_zero);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      f_enable  = 1'b1;
      fd_enable = 1'b1;
      fd_flush  = 1'b0;
      de_enable = 1'b1;
      de_flush  = 1'b0;
      em_enable = 1'b1;
      em_flush  = 1'b0;
      mw_flush  = 1'b0;
      e_mc_busy = (state == MC_BUSY);
      e_mc_done = 1'b0;

      // A memory wait freezes the whole sequencer, including the countdown.
      if (!mem_stall) begin
         case (state)
            RUN: begin
               if (e_mc_start) begin
                  state_nxt = MC_BUSY;
                  cnt_nxt   = CNT_W'(MC_CYCLES - 1);
               end
            end
            MC_BUSY: begin
               if (cnt_zero) begin
                  state_nxt = RUN;
                  e_mc_done = 1'b1;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            default: state_nxt = RUN;
         endcase
      end

      if (mem_stall) begin
         f_enable  = 1'b0;
         fd_enable = 1'b0;
         de_enable = 1'b0;
         em_enable = 1'b0;
         mw_flush  = 1'b1;
      end else if (mc_hold) begin
         f_enable  = 1'b0;
         fd_enable = 1'b0;
         de_enable = 1'b0;
         em_flush  = 1'b1;
      end else if (e_pc_src) begin
         // Branch squashes the dependent ID instruction, so no load-use stall.
         fd_flush  = 1'b1;
         de_flush  = 1'b1;
      end else if (load_use) begin
         f_enable  = 1'b0;
         fd_enable = 1'b0;
         de_flush  = 1'b1;
      end

      if (reset) begin
         f_enable  = 1'b0;
         fd_enable = 1'b0;
         fd_flush  = 1'b0;
         de_enable = 1'b0;
         de_flush  = 1'b0;
         em_enable = 1'b0;
         em_flush  = 1'b0;
         mw_flush  = 1'b0;
         e_mc_busy = 1'b0;
         e_mc_done = 1'b0;
      end
   end

`ifdef PIPECTRL_PERF_EN
   logic [31:0] perf_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_cnt <= 32'd0;
      end else if (!f_enable && (perf_cnt != 32'hFFFF_FFFF)) begin
         perf_cnt <= perf_cnt + 32'd1;
      end
   end

   assign perf_stall_cycles = perf_cnt;
`else
   assign perf_stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench for pipeline_hazard_ctrl (MC_CYCLES=4).
//             Single-cycle hazard vectors come from a table; multi-cycle,
//             memory-wait-in-busy and reset-abort cases are hand sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

   localparam int MC = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  d_rs1, d_rs2, e_rd;
   logic        d_uses_rs1, d_uses_rs2, e_is_load, e_pc_src, e_mc_start;
   logic        m_mem_req, m_mem_ready;
   logic        f_enable, fd_enable, fd_flush, de_enable, de_flush;
   logic        em_enable, em_flush, mw_flush, e_mc_busy, e_mc_done;
   logic [31:0] perf_stall_cycles;

   pipeline_hazard_ctrl #(.MC_CYCLES(MC)) dut (
      .clk(clk), .reset(reset),
      .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
      .e_rd(e_rd), .e_is_load(e_is_load), .e_pc_src(e_pc_src), .e_mc_start(e_mc_start),
      .m_mem_req(m_mem_req), .m_mem_ready(m_mem_ready),
      .f_enable(f_enable), .fd_enable(fd_enable), .fd_flush(fd_flush),
      .de_enable(de_enable), .de_flush(de_flush), .em_enable(em_enable),
      .em_flush(em_flush), .mw_flush(mw_flush), .e_mc_busy(e_mc_busy),
      .e_mc_done(e_mc_done), .perf_stall_cycles(perf_stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       ld;
      logic       pc;
      logic       mc;
      logic       mreq;
      logic       mrdy;
   } vin_t;

   typedef struct {
      vin_t       v;
      logic [9:0] e;
      string      nm;
   } vec_t;

   typedef struct {
      logic [9:0] e;
      string      nm;
   } exp_t;

   // Output order: f_en fd_en fd_fl de_en de_fl em_en em_fl mw_fl busy done
   localparam logic [9:0] E_NORM = 10'b1101010000;
   localparam logic [9:0] E_LU   = 10'b0001110000;
   localparam logic [9:0] E_BR   = 10'b1111110000;
   localparam logic [9:0] E_MEM  = 10'b0000000100;
   localparam logic [9:0] E_MCS  = 10'b0000011000;
   localparam logic [9:0] E_MCB  = 10'b0000011010;
   localparam logic [9:0] E_DONE = 10'b1101010011;
   localparam logic [9:0] E_MEMB = 10'b0000000110;
   localparam logic [9:0] E_RST  = 10'b0000000000;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;
   int   stall_model = 0;
   vec_t tbl[13];

   function automatic vin_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic ld, input logic pc, input logic mc,
                               input logic mreq, input logic mrdy);
      vin_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
      v.ld = ld; v.pc = pc; v.mc = mc; v.mreq = mreq; v.mrdy = mrdy;
      return v;
   endfunction

   function automatic logic [9:0] outs();
      return {f_enable, fd_enable, fd_flush, de_enable, de_flush,
              em_enable, em_flush, mw_flush, e_mc_busy, e_mc_done};
   endfunction

   task automatic drive(input vin_t v);
      d_rs1 = v.rs1; d_rs2 = v.rs2; d_uses_rs1 = v.u1; d_uses_rs2 = v.u2;
      e_rd = v.rd; e_is_load = v.ld; e_pc_src = v.pc; e_mc_start = v.mc;
      m_mem_req = v.mreq; m_mem_ready = v.mrdy;
   endtask

   task automatic check_vec(input logic [9:0] act, input exp_t x);
      checks++;
      if (act === x.e) passed++;
      else $display("FAIL %s: outputs got %b expected %b", x.nm, act, x.e);
   endtask

   task automatic check_perf(input string nm);
      logic [31:0] want;
`ifdef PIPECTRL_PERF_EN
      want = 32'(stall_model);
`else
      want = 32'd0;
`endif
      checks++;
      if (perf_stall_cycles === want) passed++;
      else $display("FAIL %s: perf_stall_cycles got %0d expected %0d",
                    nm, perf_stall_cycles, want);
   endtask

   // One clock cycle: drive at posedge+1, compare at negedge, return at posedge+1.
   task automatic step(input vin_t v, input logic [9:0] e, input string nm);
      exp_t x;
      drive(v);
      q.push_back('{e: e, nm: nm});
      @(negedge clk);
      x = q.pop_front();
      check_vec(outs(), x);
      if (e[9] == 1'b0) stall_model++;
      @(posedge clk);
      #1;
   endtask

   vin_t z, mcs, mms;

   initial begin
      z   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      mcs = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      mms = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

      tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E_NORM, "idle"};
      tbl[1]  = '{mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 0), E_LU,   "lu_rs1"};
      tbl[2]  = '{mk(1, 7, 0, 1, 7, 1, 0, 0, 0, 0), E_LU,   "lu_rs2"};
      tbl[3]  = '{mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0), E_NORM, "load_x0"};
      tbl[4]  = '{mk(5, 0, 0, 0, 5, 1, 0, 0, 0, 0), E_NORM, "lu_unused_rs"};
      tbl[5]  = '{mk(5, 0, 1, 0, 5, 0, 0, 0, 0, 0), E_NORM, "not_load"};
      tbl[6]  = '{mk(5, 5, 1, 1, 6, 1, 0, 0, 0, 0), E_NORM, "lu_rd_mismatch"};
      tbl[7]  = '{mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 0), E_BR,   "branch_over_lu"};
      tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), E_BR,   "branch"};
      tbl[9]  = '{mk(5, 0, 1, 0, 5, 1, 1, 0, 1, 0), E_MEM,  "mem_over_all"};
      tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), E_NORM, "mem_ready"};
      tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), E_MEM,  "mem_over_mc"};
      tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E_NORM, "mc_held_by_mem"};

      // Reset state
      reset = 1'b1;
      drive(z);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_vec(outs(), '{e: E_RST, nm: "reset_outputs"});
      check_perf("reset_perf");
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 13; i++) step(tbl[i].v, tbl[i].e, tbl[i].nm);

      // Load-use stalls exactly one cycle; then the bubble reaches EX.
      step(mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 0), E_LU, "lu_seq_stall");
      step(mk(5, 0, 1, 0, 0, 0, 0, 0, 0, 0), E_NORM, "lu_seq_next");

      // Multi-cycle: 4 hold cycles, done on the 5th.
      step(mcs, E_MCS, "mc_start");
      for (int i = 0; i < MC - 1; i++) step(mcs, E_MCB, "mc_busy");
      step(mcs, E_DONE, "mc_done");
      step(z, E_NORM, "mc_after");

      // MC start with branch: multi-cycle rule wins.
      step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0), E_MCS, "mc_over_branch");
      step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0), E_MCB, "mc_busy_branch"); // cnt 3
      // cnt now 2: memory wait for 3 cycles freezes it.
      for (int i = 0; i < 3; i++) step(mms, E_MEMB, "mc_mem_wait");
      step(mcs, E_MCB, "mc_cnt2");
      step(mcs, E_MCB, "mc_cnt1");
      step(mcs, E_DONE, "mc_cnt0_done");
      step(z, E_NORM, "mc_mem_after");

      // Reset aborts an in-flight MC_BUSY.
      step(mcs, E_MCS, "rst_mc_start");
      step(mcs, E_MCB, "rst_mc_busy");
      drive(mcs);
      #2 reset = 1'b1;
      #1 check_vec(outs(), '{e: E_RST, nm: "rst_mid_busy"});
      stall_model = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      step(z, E_NORM, "rst_after_run");
      check_perf("perf_after_reset");
      step(mcs, E_MCS, "rst_restart_run");
      for (int i = 0; i < MC - 1; i++) step(mcs, E_MCB, "rst_restart_busy");
      step(mcs, E_DONE, "rst_restart_done");

      // Seven injected memory stalls on top of the MC stalls above.
      for (int i = 0; i < 7; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), E_MEM, "perf_mem");
      step(z, E_NORM, "perf_end");
      check_perf("perf_count");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire
